// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the RAM bus controller: size codes, FSM states,
// owner codes and the latched transaction payload.
package mem_ctrl_pkg;

    localparam int unsigned RamBusW = 8;
    localparam int unsigned WordW   = 32;
    localparam int unsigned CntW    = 3;

    localparam logic [1:0] MemByte = 2'd0;
    localparam logic [1:0] MemHalf = 2'd1;
    localparam logic [1:0] MemWord = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StWrite = 2'd2
    } state_e;

    typedef enum logic {
        OwnIf  = 1'b0,
        OwnMem = 1'b1
    } owner_e;

    typedef struct packed {
        owner_e            owner;
        logic [CntW-1:0]   n;
        logic [WordW-1:0]  wdata;
    } txn_t;

    // Byte count for a size code; the unused code 3 behaves as a word.
    function automatic logic [CntW-1:0] size_to_n(input logic [1:0] size);
        case (size)
            MemByte: return 3'd1;
            MemHalf: return 3'd2;
            MemWord: return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Owner of the 8-bit external RAM bus: serialises IF fetches and MEM loads/stores
// into byte transactions, MEM having fixed priority over IF.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,

    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic [WordW-1:0]      if_inst_o,
    output logic                  if_done_o,

    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [1:0]            mem_size_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [WordW-1:0]      mem_wdata_i,
    output logic [WordW-1:0]      mem_rdata_o,
    output logic                  mem_done_o,

    input  logic [RamBusW-1:0]    ram_din_i,
    output logic [RamBusW-1:0]    ram_dout_o,
    output logic [ADDR_WIDTH-1:0] ram_a_o,
    output logic                  ram_wr_o
);

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    txn_t                  txn_q, txn_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WordW-1:0]      rdata_q, rdata_d;

    logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
    logic [RamBusW-1:0]    ram_dout_q, ram_dout_d;
    logic                  ram_wr_q, ram_wr_d;
    logic                  if_done_q, if_done_d;
    logic                  mem_done_q, mem_done_d;
    logic [WordW-1:0]      if_inst_q, if_inst_d;
    logic [WordW-1:0]      mem_rdata_q, mem_rdata_d;

    txn_t                  req_txn;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_we;
    logic                  req_any;

    logic [1:0]            cap_idx;
    logic [1:0]            nxt_idx;
    logic [WordW-1:0]      cap_word;
    logic [ADDR_WIDTH-1:0] nxt_addr;
    logic [RamBusW-1:0]    nxt_byte;
    logic                  last;

    // Fixed-priority request selection; MEM wins when both are pending.
    always_comb begin
        req_txn  = '0;
        req_addr = '0;
        req_we   = 1'b0;
        req_any  = mem_req_i || if_req_i;
        if (mem_req_i) begin
            req_txn.owner = OwnMem;
            req_txn.n     = size_to_n(mem_size_i);
            req_txn.wdata = mem_wdata_i;
            req_addr      = mem_addr_i;
            req_we        = mem_we_i;
        end else begin
            req_txn.owner = OwnIf;
            req_txn.n     = 3'd4;
            req_addr      = if_addr_i;
        end
    end

    // Read data for the address driven last cycle lands at byte cnt-1.
    assign cap_idx  = 2'(cnt_q - 3'd1);
    assign nxt_idx  = 2'(cnt_q + 3'd1);
    assign cap_word = rdata_q | (WordW'(ram_din_i) << {cap_idx, 3'b000});
    assign nxt_addr = addr_q + ADDR_WIDTH'(nxt_idx);
    assign nxt_byte = RamBusW'(txn_q.wdata >> {nxt_idx, 3'b000});
    assign last     = (cnt_q == txn_q.n - 3'd1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        txn_d       = txn_q;
        addr_d      = addr_q;
        rdata_d     = rdata_q;
        ram_a_d     = '0;
        ram_dout_d  = '0;
        ram_wr_d    = 1'b0;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            StIdle: begin
                // A done pulse in flight blocks acceptance for one cycle.
                if (req_any && !if_done_q && !mem_done_q) begin
                    txn_d      = req_txn;
                    addr_d     = req_addr;
                    cnt_d      = '0;
                    rdata_d    = '0;
                    ram_a_d    = req_addr;
                    ram_wr_d   = req_we;
                    ram_dout_d = req_we ? RamBusW'(req_txn.wdata) : '0;
                    state_d    = req_we ? StWrite : StRead;
                end
            end
            StRead: begin
                if (cnt_q != '0) begin
                    rdata_d = cap_word;
                end
                if (cnt_q == txn_q.n) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    if (txn_q.owner == OwnMem) begin
                        mem_done_d  = 1'b1;
                        mem_rdata_d = cap_word;
                    end else begin
                        if_done_d = 1'b1;
                        if_inst_d = cap_word;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (!last) begin
                        ram_a_d = nxt_addr;
                    end
                end
            end
            StWrite: begin
                if (last) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    if (txn_q.owner == OwnMem) begin
                        mem_done_d = 1'b1;
                    end else begin
                        if_done_d = 1'b1;
                    end
                end else begin
                    cnt_d      = cnt_q + 3'd1;
                    ram_a_d    = nxt_addr;
                    ram_wr_d   = 1'b1;
                    ram_dout_d = nxt_byte;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // rdy low freezes every register, which also stretches done pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            txn_q       <= '0;
            addr_q      <= '0;
            rdata_q     <= '0;
            ram_a_q     <= '0;
            ram_dout_q  <= '0;
            ram_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
        end else if (rdy) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            txn_q       <= txn_d;
            addr_q      <= addr_d;
            rdata_q     <= rdata_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign ram_a_o     = ram_a_q;
    assign ram_dout_o  = ram_dout_q;
    assign ram_wr_o    = ram_wr_q;
    assign if_done_o   = if_done_q;
    assign if_inst_o   = if_inst_q;
    assign mem_done_o  = mem_done_q;
    assign mem_rdata_o = mem_rdata_q;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller for the RV32I core: the single owner of the 8-bit external RAM bus (`mem_din`/`mem_dout`/`mem_a`/`mem_wr`). It serialises 32-bit instruction fetches from the IF stage and byte/half/word loads and stores from the MEM stage into byte transactions and arbitrates between the two. Requesters see a req/done handshake, and the top level feeds pending-but-not-done into `ctrl` as stall requests.

## Interface
- `ADDR_WIDTH`, 32, width of all address ports (RAM decodes only [17:0]).
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Asynchronous and active-low.
- `rdy`  in  1  global ready; low freezes the block.
- `if_req_i`  in  1  fetch request, held until `if_done_o`.
- `if_addr_i`  in  ADDR_WIDTH  fetch address.
- `if_inst_o`  out  32  fetched word, valid while `if_done_o`.
- `if_done_o`  out  1  one-cycle completion pulse.
- `mem_req_i`  in  1  data request, held until `mem_done_o`.
- `mem_we_i`  in  1  1 = store, 0 = load.
- `mem_size_i`  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `mem_addr_i`  in  ADDR_WIDTH  data address.
- `mem_wdata_i`  in  32  store data, low bytes used.
- `mem_rdata_o`  out  32  load data, zero-extended, valid while `mem_done_o`.
- `mem_done_o`  out  1  one-cycle completion pulse.
- `ram_din_i`  in  8  RAM read byte.
- `ram_dout_o`  out  8  RAM write byte.
- `ram_a_o`  out  ADDR_WIDTH  RAM address.
- `ram_wr_o`  out  1  1 = write.

## Operation
- FSM states: IDLE, READ, WRITE. A 3-bit byte counter `cnt` and a latched owner (IF/MEM), address, size n (1/2/4) and write data.
- Acceptance happens only in IDLE, and only in a cycle with no done pulse asserted. A requester whose done is high in that cycle is ignored, which gives a mandatory one-cycle gap between transactions.
- Arbitration is fixed priority: MEM beats IF when both are requesting. An in-flight transaction is never pre-empted.
- Read of n bytes: during cycle k (k = 0..n-1) after acceptance, drive `ram_a_o` = addr+k and `ram_wr_o` = 0. RAM is synchronous, so the byte for the address driven in cycle c is valid on `ram_din_i` in cycle c+1. It is captured into bits [8k+7:8k].
- Write of n bytes: during cycle k, drive `ram_a_o` = addr+k, `ram_dout_o` = wdata[8k+7:8k] and `ram_wr_o` = 1.
- Byte order is little-endian. Address increment is modulo 2^ADDR_WIDTH. No alignment check is made.
- Load data is not sign-extended here; the MEM stage applies funct3 sign extension.
- Idle outputs: `ram_wr_o` = 0, `ram_a_o` = 0, `ram_dout_o` = 0.
- `rdy` low: state, counter, captured data and all outputs hold their values, and nothing is sampled. The RAM shares `rdy`, so no byte is lost. Done pulses are also stretched while `rdy` is low.
- Reset at any time, including mid-transaction: IDLE, all outputs 0, the transaction is abandoned with no done pulse. A partially completed store leaves the already-written bytes in RAM.

## Timing
- Reset values: all outputs 0, state IDLE, `cnt` 0.
- Request sampled high at edge E0. Bus activity begins in the cycle after E0.
- Read of n bytes: addresses are driven in cycles 1..n, the last byte is captured at the end of cycle n+1, and done plus data are valid in cycle n+2. Latencies: word 6, half 4, byte 3.
- Write of n bytes: bytes are driven in cycles 1..n and done is asserted in cycle n+1. Latencies: word 5, byte 2.
- Earliest next acceptance is the edge that ends the done cycle plus one cycle.
- Outputs are registered, with no combinational path from req to the RAM bus.

## Structure
- Constants go in `defines.v`:
  - size codes `MemByte`, `MemHalf`, `MemWord`;
  - state encodings;
  - `RamBus` 7:0;
  - owner codes.
- Single module. No sub-module is required; byte assembly and lane selection are inline shift/mux.

## Test plan
- Word fetch: `if_addr_i` = 0x1000, RAM[0x1000..3] = 13 05 00 00 -> `if_done_o` in cycle 6 with `if_inst_o` = 0x00000513, `ram_wr_o` never 1.
- Byte store: addr 0x30004, wdata 0x123456AB -> one cycle with `ram_wr_o` = 1, `ram_a_o` = 0x30004, `ram_dout_o` = 0xAB; `mem_done_o` in cycle 2.
- Simultaneous requests: MEM word load at 0x200 and IF fetch at 0x0 in the same cycle -> the MEM load completes first (cycle 6), then the IF fetch is accepted after the gap and `if_done_o` is asserted 6 cycles after acceptance.
- `rdy` held low for 3 cycles during byte 2 of a word load of 0xDEADBEEF -> `mem_rdata_o` = 0xDEADBEEF, done delayed by exactly 3 cycles, bus frozen throughout.
- Half load at 0xFFFFFFFF -> addresses 0xFFFFFFFF then 0x00000000; result = {RAM[0], RAM[0xFFFFFFFF]} zero-extended.
- `rst` asserted low mid word store (after byte 1) -> outputs 0 immediately without waiting for a clock edge, no done pulse; after release, a new IF request is accepted normally.
